mem_port_arbiter: RTL

//  Shares a single main-memory port between N_REQ cache controllers (e.g. I-cache and D-cache).

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between N_REQ cache controllers.
// The owner may keep the port across a write-back/refill pair, and a stalled GRANT times out.
module mem_port_arbiter #(
   parameter int N_REQ       = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int LOCK_BURST  = 1,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_rd,
   input  logic [N_REQ-1:0]        req_wr,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        gnt_ready,
   output logic [N_REQ-1:0]        gnt,
   output logic                    mem_rd_en,
   output logic                    mem_wr_en,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic                    mem_ready,
   output logic                    timeout_err
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [PTR_W-1:0]   owner_r, owner_nxt_s;
   logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic               timeout_err_r, timeout_nxt_s;
   logic [N_REQ-1:0]   active_s;
   logic [PTR_W-1:0]   pick_s;
   logic               pick_vld_s;
   logic [PTR_W-1:0]   owner_inc_s;
   logic               owner_active_s;

   assign active_s       = req_rd | req_wr;
   assign owner_active_s = active_s[owner_r];
   assign owner_inc_s    = (owner_r == PTR_LAST) ? PTR_ZERO : (owner_r + PTR_W'(1));
   assign timeout_err    = timeout_err_r;

   // Round-robin scan: first active requester at or after rr_ptr, wrapping modulo N_REQ
   always_comb begin
      int idx;
      pick_s     = PTR_ZERO;
      pick_vld_s = 1'b0;
      idx        = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(rr_ptr_r) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end else begin
            idx = idx;
         end
         if (!pick_vld_s && active_s[idx]) begin
            pick_s     = PTR_W'(idx);
            pick_vld_s = 1'b1;
         end else begin
            pick_vld_s = pick_vld_s;
         end
      end
   end

   // Next-state logic; completion takes priority over owner drop and timeout
   always_comb begin
      state_nxt_s   = state_r;
      owner_nxt_s   = owner_r;
      rr_ptr_nxt_s  = rr_ptr_r;
      cnt_nxt_s     = cnt_r;
      timeout_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = CNT_ZERO;
            if (pick_vld_s) begin
               owner_nxt_s = pick_s;
               state_nxt_s = ST_GRANT;
            end else begin
               owner_nxt_s = PTR_ZERO;
            end
         end
         ST_GRANT: begin
            if (mem_ready) begin
               state_nxt_s  = ST_RELEASE;
               rr_ptr_nxt_s = owner_inc_s;
               cnt_nxt_s    = CNT_ZERO;
            end else if (!owner_active_s) begin
               state_nxt_s  = ST_IDLE;
               rr_ptr_nxt_s = owner_inc_s;
               owner_nxt_s  = PTR_ZERO;
               cnt_nxt_s    = CNT_ZERO;
            end else if ((TIMEOUT_CYC != 0) && (cnt_r == CNT_LAST)) begin
               state_nxt_s   = ST_RELEASE;
               rr_ptr_nxt_s  = owner_inc_s;
               timeout_nxt_s = 1'b1;
               cnt_nxt_s     = CNT_ZERO;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            cnt_nxt_s = CNT_ZERO;
            if ((LOCK_BURST != 0) && owner_active_s) begin
               state_nxt_s = ST_GRANT;
            end else begin
               state_nxt_s = ST_IDLE;
               owner_nxt_s = PTR_ZERO;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            owner_nxt_s = PTR_ZERO;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, owner, pointer, watchdog counter and timeout pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         owner_r       <= PTR_ZERO;
         rr_ptr_r      <= PTR_ZERO;
         cnt_r         <= CNT_ZERO;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         owner_r       <= owner_nxt_s;
         rr_ptr_r      <= rr_ptr_nxt_s;
         cnt_r         <= cnt_nxt_s;
         timeout_err_r <= timeout_nxt_s;
      end
   end

   // Memory-side mux from the owner; enables and ready only while in GRANT, write wins over read
   always_comb begin
      gnt       = {N_REQ{1'b0}};
      gnt_ready = {N_REQ{1'b0}};
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      if (state_r != ST_IDLE) begin
         gnt[owner_r] = 1'b1;
         mem_addr     = req_addr[int'(owner_r)*ADDR_W +: ADDR_W];
         mem_wdata    = req_wdata[int'(owner_r)*DATA_W +: DATA_W];
      end else begin
         gnt = {N_REQ{1'b0}};
      end
      if (state_r == ST_GRANT) begin
         mem_wr_en          = req_wr[owner_r];
         mem_rd_en          = req_rd[owner_r] & ~req_wr[owner_r];
         gnt_ready[owner_r] = mem_ready;
      end else begin
         gnt_ready = {N_REQ{1'b0}};
      end
   end

endmodule
